// File: rtl/seq_detect_cnt.sv
// seq_detect_cnt: serial pattern detector and match counter; defining SEQ_DETECT_SAT_EN makes count saturate and adds sat
module seq_detect_cnt #(
  parameter int PAT_W = 2,
  parameter logic [PAT_W-1:0] PATTERN = 2'b01,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             en,
  input  logic             clr,
  input  logic             overlap,
  output logic             z,
  output logic [CNT_W-1:0] count,
  output logic             primed
`ifdef SEQ_DETECT_SAT_EN
  ,
  output logic             sat
`endif
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  typedef enum logic [1:0] {FILLING, ARMED, HIT} state_t;
  state_t state, state_d;
  logic [PAT_W-1:0] hist, hist_d, w;
  logic [FW-1:0] fill, fill_d;
  logic [CNT_W-1:0] count_d;
  logic match;
  // window/match evaluation and next values; clr wins over en and discards a same-cycle match
  always_comb begin
    w = {hist[PAT_W-2:0], x};
    match = en && (fill >= FULL - FW'(1)) && (w == PATTERN);
    hist_d = clr ? '0 : en ? w : hist;
    fill_d = clr ? '0 : !en ? fill : (match && !overlap) ? '0 : (fill == FULL) ? FULL : fill + FW'(1);
`ifdef SEQ_DETECT_SAT_EN
    count_d = clr ? '0 : (match && count != '1) ? count + CNT_W'(1) : count;
`else
    count_d = clr ? '0 : match ? count + CNT_W'(1) : count;
`endif
    state_d = clr ? FILLING : match ? HIT : (fill_d == FULL) ? ARMED : FILLING;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      count <= '0;
      state <= FILLING;
    end else begin
      hist  <= hist_d;
      fill  <= fill_d;
      count <= count_d;
      state <= state_d;
    end
  end
  assign z = (state == HIT);
  assign primed = (fill == FULL);
`ifdef SEQ_DETECT_SAT_EN
  assign sat = (count == '1);
`endif
endmodule

// File: doc/seq_detect_cnt.md
Name: seq_detect_cnt

Overview:
Parametrised serial pattern detector and match counter.
- Samples a 1-bit serial input `x` each clock.
- Compares the most recent PAT_W bits against a programmable PATTERN.
- Pulses `z` on every match and accumulates matches in a counter.
- Successor to the fixed "01" detector: arbitrary pattern width and value, overlap/non-overlap mode, enable, clear and count output; used as a stream-monitoring block in lab datapaths.

Parameters:
PAT_W, 2, pattern length in bits (2..16).
PATTERN, 2'b01, pattern value (PAT_W bits); MSB is the earliest-received bit.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
x  input  1  serial data bit, sampled on rising clk when en=1.
en  input  1  sample enable; when 0, x is ignored and all state holds.
clr  input  1  synchronous clear of count, history and fill level.
overlap  input  1  1 = overlapping matches; 0 = non-overlapping.
z  output  1  one-cycle match pulse (registered).
count  output  CNT_W  number of matches since reset/clr.
primed  output  1  high once PAT_W bits have been collected since reset/clr/last non-overlap match.

Behaviour:
- Reset (rst_n=0, async): shift register=0, fill=0, z=0, count=0, primed=0. Remains in effect until rst_n rises; the first sample is taken on the first clk edge after release.
- State:
  - shift register `hist[PAT_W-1:0]`;
  - fill counter `fill` (0..PAT_W, saturating at PAT_W);
  - primed = (fill == PAT_W), registered.
- On each rising clk with en=1, clr=0:
  - Next window w = {hist[PAT_W-2:0], x}.
  - match = ((fill+1 >= PAT_W) && (w == PATTERN)).
  - hist <= w.
  - On match: z <= 1; count increments.
  - On match with overlap=0: fill <= 0, so the next match needs PAT_W fresh bits.
  - Otherwise: fill <= min(fill+1, PAT_W).
  - No match: z <= 0.
- Latency: z rises exactly one clk after the edge that samples the completing bit; z is high for exactly one cycle per match.
- en=0: hist, fill, count hold; z <= 0.
- clr=1 (any en): hist <= 0, fill <= 0, z <= 0, count <= 0. clr has priority over en and over a same-cycle match; that match is discarded.
- Pattern bits are never matched against reset-zero history: leading zeros in PATTERN still require real sampled bits (fill check).
- overlap may change at any cycle. It affects only the fill update on the edge where it is sampled with a match.
- Counter overflow: wraps modulo 2^CNT_W (default build).
- Mode is level-sensitive; no internal FSM beyond hist/fill/count. Implement as registered datapath plus a 3-state control view: FILLING (fill<PAT_W), ARMED (fill==PAT_W), HIT (z=1). HIT returns to ARMED if overlap=1, or to FILLING if overlap=0.

Optional Feature:
SEQ_DETECT_SAT_EN
- Defined: count saturates at 2^CNT_W-1 and holds. Adds output `sat` (1 bit), which asserts the cycle count reaches max and clears only on reset/clr. z still pulses on every match.
- Undefined: count wraps to 0 after 2^CNT_W-1; no `sat` port.

Test Plan:
1. Defaults (PAT_W=2, PATTERN=01), en=1, overlap=1; x stream 0,0,1,0,0,0,1,1,1,0,1,1,0,0 -> z pulses 3 times (after the 3rd, 7th and 11th samples); final count=3.
2. PAT_W=3, PATTERN=101, x=1,0,1,0,1 -> overlap=1: count=2, z after samples 3 and 5; overlap=0: count=1, z after sample 3 only.
3. PAT_W=3, PATTERN=000, x=0 after reset -> no z until the 3rd sample; z on sample 3 (primed=1); with overlap=1, z every cycle thereafter.
4. Mid-stream en=0 for 4 cycles between bits 0 and 1 of PATTERN=01 -> match still detected on the next enabled 1; count increments once; z stays 0 while en=0.
5. clr asserted on the same edge as a completing bit -> z stays 0, count=0, primed=0. rst_n pulsed low mid-cycle -> z, count, primed drop to 0 immediately (async).
6. CNT_W=2, 5 matches -> count=1 (wrap) without SEQ_DETECT_SAT_EN; count=3 and sat=1 with it defined.
